eprom8755_responder: RTL

- Bus-side model of an 8755 EPROM for the PGM8755 board.
- Sits at the far end of the multiplexed AD/ALE/CE/RD/data_latch bus driven by the programmer.
- Captures programming pulses into an internal 2K x 8 array and answers verify reads.
- Used as a loopback target for programmer bring-up and as a stand-in device in system benches.

---
 rtl/pgm8755_pkg.sv | 16 +
 rtl/eprom_array.sv | 24 ++
 rtl/eprom8755_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pgm8755_pkg.sv
// rtl/pgm8755_pkg.sv - shared types and constants for the PGM8755 programmer and its 8755 responder
package pgm8755_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int PROG_PULSE_CYCLES = 1000000;
  localparam logic [DATA_W-1:0] ERASED_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    PROG   = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/eprom_array.sv
// rtl/eprom_array.sv - 2K x 8 EPROM cell array, writes can only clear bits
module eprom_array #(
  parameter int ADDR_W = pgm8755_pkg::ADDR_W,
  parameter int DATA_W = pgm8755_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import pgm8755_pkg::*;

  // Erased EPROM cells read as all ones; contents survive reset.
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: ERASED_BYTE};

  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= mem[addr] & wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/eprom8755_responder.sv
// rtl/eprom8755_responder.sv - bus-side 8755 EPROM model answering program pulses and verify reads
module eprom8755_responder #(
  parameter int ADDR_W          = pgm8755_pkg::ADDR_W,
  parameter int DATA_W          = pgm8755_pkg::DATA_W,
  parameter int PROG_MIN_CYCLES = pgm8755_pkg::PROG_PULSE_CYCLES,
  parameter int READ_LATENCY    = 2,
  parameter int CTR_W           = $clog2(PROG_MIN_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ale,
  input  logic              ce,
  input  logic              rd,
  input  logic              data_latch,
  input  logic [ADDR_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              prog_done,
  output logic              prog_err,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [ADDR_W:0]   byte_count
);
  import pgm8755_pkg::*;

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [ADDR_W:0] BC_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0] ale_q, ce_q, rd_q, dl_q;
  logic ale_s, ce_s, rd_s, dl_s;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] data_lat;
  logic [DATA_W-1:0] rdata;
  logic [CTR_W-1:0] pulse_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic oe_q;
  logic commit_ok;
  logic we;
  state_t state;

  // Synchronizers come out of reset at the bus idle levels so no strobe is seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ale_q <= 2'b00;
      ce_q  <= 2'b00;
      rd_q  <= 2'b11;
      dl_q  <= 2'b11;
    end else begin
      ale_q <= {ale_q[0], ale};
      ce_q  <= {ce_q[0], ce};
      rd_q  <= {rd_q[0], rd};
      dl_q  <= {dl_q[0], data_latch};
    end
  end

  assign ale_s = ale_q[1];
  assign ce_s  = ce_q[1];
  assign rd_s  = rd_q[1];
  assign dl_s  = dl_q[1];

  // Address and data are captured on raw strobes, ahead of the synchronized FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_lat <= '0;
      data_lat <= '0;
    end else begin
      if (ale) begin
        addr_lat <= ad_in;
      end
      if (ce && !data_latch && !ale) begin
        data_lat <= ad_in[DATA_W-1:0];
      end
    end
  end

  assign commit_ok = (pulse_cnt >= CTR_W'(PROG_MIN_CYCLES));
  assign we        = rst && (state == COMMIT) && commit_ok;

  eprom_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (addr_lat),
    .wdata(data_lat),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      lat_cnt    <= '0;
      oe_q       <= 1'b0;
      ad_out     <= '0;
      prog_done  <= 1'b0;
      prog_err   <= 1'b0;
      prog_addr  <= '0;
      byte_count <= '0;
    end else begin
      prog_done <= 1'b0;
      prog_err  <= 1'b0;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (ce_s && !dl_s && !ale_s) begin
            state     <= PROG;
            pulse_cnt <= '0;
          end else if (!ce_s && !rd_s && !ale_s) begin
            state <= READ;
          end
        end
        PROG: begin
          if (pulse_cnt < CTR_W'(PROG_MIN_CYCLES)) begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
          if (dl_s || !ce_s || ale_s) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            prog_done <= 1'b1;
            if (byte_count != BC_MAX) begin
              byte_count <= byte_count + 1'b1;
            end
          end else begin
            prog_err <= 1'b1;
          end
          prog_addr <= addr_lat;
          state     <= IDLE;
        end
        READ: begin
          if (rd_s || ce_s || ale_s) begin
            oe_q  <= 1'b0;
            state <= IDLE;
          end else if (lat_cnt >= LAT_W'(READ_LATENCY - 1)) begin
            oe_q   <= 1'b1;
            ad_out <= rdata;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The bus is never driven while the device is being programmed.
  assign ad_oe = oe_q && !ce_s;

endmodule
